// File: rtl/melody_seq.sv
// melody_seq: score-driven square-wave tone sequencer with per-pitch half-period table,
// note/gap articulation timing, looping and abort.
module melody_seq #(
    parameter int STEPS    = 32,
    parameter int PITCH_W  = 4,
    parameter int DUR_W    = 3,
    parameter int HALF_W   = 18,
    parameter int BEAT_CYC = 6250000,
    parameter int GAP_CYC  = 500000,
    localparam int AW      = $clog2(STEPS)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     stop,
    input  logic                     loop,
    input  logic [AW:0]              len,
    input  logic                     score_we,
    input  logic [AW-1:0]            score_addr,
    input  logic [PITCH_W+DUR_W-1:0] score_wdata,
    input  logic                     tbl_we,
    input  logic [PITCH_W-1:0]       tbl_addr,
    input  logic [HALF_W-1:0]        tbl_wdata,
    output logic                     nota,
    output logic                     busy,
    output logic [AW-1:0]            step,
    output logic                     done
);
    localparam int CW = $clog2((2**DUR_W) * BEAT_CYC + 1);
    localparam logic [1:0] IDLE = 2'd0, LOAD = 2'd1, TONE = 2'd2, GAP = 2'd3;

    logic [PITCH_W+DUR_W-1:0] score [STEPS];
    logic [HALF_W-1:0]        tbl [2**PITCH_W];
    logic [1:0]               state;
    logic [PITCH_W-1:0]       pitch;
    logic [DUR_W-1:0]         dur;
    logic [HALF_W-1:0]        half, tcnt;
    logic [CW-1:0]            cnt, tone_last;
    logic [AW:0]              len_c, step_nx;
    logic [PITCH_W+DUR_W-1:0] entry;

    always_ff @(posedge clk) begin
        if (score_we) score[score_addr] <= score_wdata;
        if (tbl_we) tbl[tbl_addr] <= tbl_wdata;
    end

    always_comb begin
        entry     = score[step];
        len_c     = (len > (AW+1)'(STEPS)) ? (AW+1)'(STEPS) : len;
        step_nx   = {1'b0, step} + 1'b1;
        tone_last = CW'((int'(dur) + 1) * BEAT_CYC - GAP_CYC - 1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            nota  <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
            step  <= '0;
            pitch <= '0;
            dur   <= '0;
            half  <= '0;
            tcnt  <= '0;
            cnt   <= '0;
        end else begin
            done <= 1'b0;
            if (state != IDLE && stop) begin
                state <= IDLE;
                busy  <= 1'b0;
                nota  <= 1'b0;
            end else begin
                case (state)
                    IDLE: if (start && !stop && len != '0) begin
                        state <= LOAD;
                        busy  <= 1'b1;
                        step  <= '0;
                    end
                    LOAD: begin
                        pitch <= entry[PITCH_W+DUR_W-1:DUR_W];
                        dur   <= entry[DUR_W-1:0];
                        half  <= tbl[entry[PITCH_W+DUR_W-1:DUR_W]];
                        nota  <= 1'b0;
                        tcnt  <= '0;
                        cnt   <= '0;
                        state <= TONE;
                    end
                    TONE: if (cnt == tone_last) begin
                        cnt   <= '0;
                        nota  <= 1'b0;
                        state <= GAP;
                    end else begin
                        cnt <= cnt + 1'b1;
                        // rests and unprogrammed pitches (half=0) stay silent
                        if (pitch != '0 && half != '0) begin
                            if (tcnt == half - 1'b1) begin
                                tcnt <= '0;
                                nota <= ~nota;
                            end else begin
                                tcnt <= tcnt + 1'b1;
                            end
                        end
                    end
                    GAP: if (cnt == CW'(GAP_CYC - 1)) begin
                        cnt <= '0;
                        if (step_nx < len_c) begin
                            step  <= step_nx[AW-1:0];
                            state <= LOAD;
                        end else if (loop) begin
                            step  <= '0;
                            state <= LOAD;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_melody_seq.sv
// tb_melody_seq: vector table plus cycle-level scoreboard for melody_seq
// (STEPS=8, BEAT_CYC=20, GAP_CYC=4).
module tb_melody_seq;
    logic        clk, rst_n, start, stop, loop;
    logic [3:0]  len;
    logic        score_we;
    logic [2:0]  score_addr;
    logic [6:0]  score_wdata;
    logic        tbl_we;
    logic [3:0]  tbl_addr;
    logic [17:0] tbl_wdata;
    logic        nota, busy, done;
    logic [2:0]  step;

    typedef struct packed {logic busy; logic nota; logic done; logic [2:0] step;} obs_t;
    typedef struct {logic [3:0] pitch; logic [2:0] dur; logic [17:0] half; int cycles;} vec_t;

    obs_t q[$];
    vec_t vecs[6];
    int tests = 0, fails = 0, busy_cnt = 0;

    melody_seq #(.STEPS(8), .BEAT_CYC(20), .GAP_CYC(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .loop(loop), .len(len),
        .score_we(score_we), .score_addr(score_addr), .score_wdata(score_wdata),
        .tbl_we(tbl_we), .tbl_addr(tbl_addr), .tbl_wdata(tbl_wdata),
        .nota(nota), .busy(busy), .step(step), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    // cycle monitor: one expected record per cycle once a playback is queued
    initial forever begin
        obs_t e, a;
        @(negedge clk);
        if (busy) busy_cnt++;
        if (q.size() > 0) begin
            e = q.pop_front();
            a = '{busy: busy, nota: nota, done: done, step: step};
            tests++;
            if (a !== e) begin
                fails++;
                $display("FAIL seq t=%0t got busy=%b nota=%b done=%b step=%0d exp busy=%b nota=%b done=%b step=%0d",
                         $time, a.busy, a.nota, a.done, a.step, e.busy, e.nota, e.done, e.step);
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
        end
    endtask

    function automatic void push_note(input logic [3:0] p, input logic [2:0] d, input logic [17:0] h, input logic [2:0] s);
        int t = (int'(d) + 1) * 20 - 4;
        q.push_back('{1'b1, 1'b0, 1'b0, s});
        for (int j = 1; j <= t; j++)
            q.push_back('{1'b1, (p != 0 && h != 0) ? 1'(((j - 1) / int'(h)) % 2) : 1'b0, 1'b0, s});
        for (int j = 0; j < 4; j++) q.push_back('{1'b1, 1'b0, 1'b0, s});
    endfunction

    function automatic void push_end(input logic [2:0] s);
        q.push_back('{1'b0, 1'b0, 1'b1, s});
        q.push_back('{1'b0, 1'b0, 1'b0, s});
    endfunction

    task automatic drain(input int budget);
        int n = 0;
        while (q.size() != 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        if (q.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL drain_timeout left=%0d exp=0", q.size());
            q.delete();
        end
    endtask

    task automatic wr_score(input logic [2:0] a, input logic [6:0] d);
        @(posedge clk); #1 score_we = 1'b1; score_addr = a; score_wdata = d;
        @(posedge clk); #1 score_we = 1'b0;
    endtask

    task automatic wr_tbl(input logic [3:0] a, input logic [17:0] d);
        @(posedge clk); #1 tbl_we = 1'b1; tbl_addr = a; tbl_wdata = d;
        @(posedge clk); #1 tbl_we = 1'b0;
    endtask

    task automatic start_pulse();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; stop = 1'b0; loop = 1'b0; len = 4'd1;
        score_we = 1'b0; score_addr = '0; score_wdata = '0;
        tbl_we = 1'b0; tbl_addr = '0; tbl_wdata = '0;
        vecs[0] = '{4'd1, 3'd0, 18'd3,   21};
        vecs[1] = '{4'd0, 3'd1, 18'd5,   41};
        vecs[2] = '{4'd2, 3'd0, 18'd0,   21};
        vecs[3] = '{4'd3, 3'd2, 18'd7,   61};
        vecs[4] = '{4'd4, 3'd0, 18'd1,   21};
        vecs[5] = '{4'd5, 3'd7, 18'd40, 161};
        #12;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_nota", 32'(nota), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_step", 32'(step), 0);
        @(negedge clk) rst_n = 1'b1;

        foreach (vecs[i]) begin
            wr_tbl(vecs[i].pitch, vecs[i].half);
            wr_score(3'd0, {vecs[i].pitch, vecs[i].dur});
            busy_cnt = 0;
            start_pulse();
            push_note(vecs[i].pitch, vecs[i].dur, vecs[i].half, 3'd0);
            push_end(3'd0);
            drain(300);
            chk($sformatf("busy_cycles[%0d]", i), 32'(busy_cnt), 32'(vecs[i].cycles));
        end

        len = 4'd0;
        start_pulse();
        @(negedge clk) chk("len0_busy", 32'(busy), 0);
        repeat (2) @(negedge clk);
        chk("len0_busy_later", 32'(busy), 0);

        // stray start while busy, score/table rewrite mid-note, loop into the new note
        wr_tbl(4'd1, 18'd3);
        wr_tbl(4'd2, 18'd2);
        wr_score(3'd0, {4'd1, 3'd0});
        len = 4'd1; loop = 1'b1;
        start_pulse();
        push_note(4'd1, 3'd0, 18'd3, 3'd0);
        push_note(4'd2, 3'd0, 18'd2, 3'd0);
        push_end(3'd0);
        repeat (3) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        @(posedge clk); #1 score_we = 1'b1; score_addr = 3'd0; score_wdata = {4'd2, 3'd0};
        tbl_we = 1'b1; tbl_addr = 4'd1; tbl_wdata = 18'd5;
        @(posedge clk); #1 score_we = 1'b0; tbl_we = 1'b0;
        repeat (24) @(posedge clk);
        #1 loop = 1'b0;
        drain(200);

        // two-step loop, loop released during the second pass of step 1
        wr_tbl(4'd1, 18'd3);
        wr_score(3'd0, {4'd1, 3'd0});
        wr_score(3'd1, {4'd2, 3'd0});
        len = 4'd2; loop = 1'b1;
        start_pulse();
        push_note(4'd1, 3'd0, 18'd3, 3'd0);
        push_note(4'd2, 3'd0, 18'd2, 3'd1);
        push_note(4'd1, 3'd0, 18'd3, 3'd0);
        push_note(4'd2, 3'd0, 18'd2, 3'd1);
        push_end(3'd1);
        repeat (68) @(posedge clk);
        #1 loop = 1'b0;
        drain(200);

        for (int i = 0; i < 8; i++) wr_score(3'(i), 7'd0);
        len = 4'd15;
        start_pulse();
        for (int i = 0; i < 8; i++) push_note(4'd0, 3'd0, 18'd0, 3'(i));
        push_end(3'd7);
        drain(400);

        wr_score(3'd0, {4'd1, 3'd0});
        wr_score(3'd1, {4'd1, 3'd1});
        len = 4'd2;
        start_pulse();
        repeat (26) @(posedge clk);
        #1 chk("pre_stop_nota", 32'(nota), 1);
        chk("pre_stop_step", 32'(step), 1);
        stop = 1'b1;
        @(posedge clk); #1 stop = 1'b0;
        chk("stop_busy", 32'(busy), 0);
        chk("stop_nota", 32'(nota), 0);
        chk("stop_done", 32'(done), 0);
        chk("stop_step", 32'(step), 1);
        @(posedge clk); #1 chk("stop_done_later", 32'(done), 0);
        start = 1'b1; stop = 1'b1;
        @(posedge clk); #1 start = 1'b0; stop = 1'b0;
        chk("start_stop_busy", 32'(busy), 0);
        @(posedge clk); #1 chk("start_stop_busy_later", 32'(busy), 0);

        len = 4'd1;
        start_pulse();
        repeat (5) @(posedge clk);
        #1 chk("pre_rst_nota", 32'(nota), 1);
        #2 rst_n = 1'b0;
        #1 chk("async_rst_nota", 32'(nota), 0);
        chk("async_rst_busy", 32'(busy), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1 chk("no_resume_busy", 32'(busy), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
